// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared datapath types.
//   word_t      : 32-bit machine word
//   ramstate_t  : handshake state reported by the single-ported RAM
//   arb_state_t : grant state of mem_arbiter
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the instruction-fetch request lines, data-memory request lines and
//   the RAM port that mem_arbiter sits between.
//   modport slave  : the arbiter (consumes requests and RAM status, drives hits
//                    and the RAM command)
//   modport master : the environment (pipeline requesters plus RAM model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // instruction fetch side
    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;

    // data side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating counter of consecutive data grants taken while an instruction
//   fetch was waiting.  Saturates at MAX; clear has priority over increment.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count one more data grant (ignored once saturated)
//     clr        : return to zero
//     sat        : counter has reached MAX
//   W must satisfy 2**W > MAX.
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;

    assign sat = (cnt == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + ONE_V;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Serialises instruction-fetch and data-memory requests onto one RAM port.
//   Data requests win, except that after STARVE_MAX consecutive data grants
//   with a fetch pending, the fetch is granted next.  The granted request is
//   latched and held on the RAM port until the RAM reports ACCESS (hit this
//   cycle) or ERROR (no hit, sticky err, requester re-arbitrated).
//   Ports:
//     CLK, nRST : clock, asynchronous active-low reset
//     bus       : mem_arbiter_if.slave (request lines, hits, RAM port)
//     err       : sticky RAM error flag, cleared only by reset
//     icount,
//     dcount    : completed fetch / data access counters (wrap at 2**32),
//                 present only when MEM_ARBITER_STATS_EN is defined
//   Parameters:
//     STARVE_MAX : data grants allowed while a fetch waits
//     CNT_W      : starvation counter width, 2**CNT_W > STARVE_MAX
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus,
    output logic         err
`ifdef MEM_ARBITER_STATS_EN
    ,
    output word_t        icount,
    output word_t        dcount
`endif
);

    arb_state_t state, next_state;

    // request captured on the grant edge; the requester may change its
    // address/data lines afterwards without disturbing the access
    word_t lat_addr;
    word_t lat_data;
    logic  lat_w;

    logic  grant_i, grant_d;
    logic  ram_err;
    logic  starve_sat;
    logic  ihit_c, dhit_c;
    logic  d_req;

    assign d_req = bus.dREN | bus.dWEN;

    // -------------------------------------------------------------------------
    // next state, grant decision and output mux
    // -------------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        ram_err      = 1'b0;
        ihit_c       = 1'b0;
        dhit_c       = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (d_req && !(bus.iREN && starve_sat)) begin
                    next_state = DACCESS;
                    grant_d    = 1'b1;
                end else if (bus.iREN) begin
                    next_state = IFETCH;
                    grant_i    = 1'b1;
                end
            end

            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = lat_addr;
                if (bus.ramstate == ACCESS) begin
                    ihit_c     = 1'b1;
                    bus.iload  = bus.ramload;
                    next_state = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    ram_err    = 1'b1;
                    next_state = IDLE;
                end
            end

            DACCESS: begin
                bus.ramREN   = ~lat_w;
                bus.ramWEN   = lat_w;
                bus.ramaddr  = lat_addr;
                bus.ramstore = lat_data;
                if (bus.ramstate == ACCESS) begin
                    dhit_c     = 1'b1;
                    // stores complete with a zero load word
                    bus.dload  = lat_w ? '0 : bus.ramload;
                    next_state = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    ram_err    = 1'b1;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    assign bus.ihit = ihit_c;
    assign bus.dhit = dhit_c;

    // -------------------------------------------------------------------------
    // state register, request latches, sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            lat_w    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                lat_addr <= bus.daddr;
                lat_data <= bus.dstore;
                // a request with both enables set is treated as a store
                lat_w    <= bus.dWEN;
            end else if (grant_i) begin
                lat_addr <= bus.iaddr;
                lat_w    <= 1'b0;
            end
            if (ram_err) begin
                err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // anti-starvation: count data grants that jumped a waiting fetch
    // -------------------------------------------------------------------------
    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (grant_d & bus.iREN),
        .clr   (grant_i | (grant_d & ~bus.iREN)),
        .sat   (starve_sat)
    );

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (ihit_c) icount <= icount + 32'd1;
            if (dhit_c) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by a randomized phase.  The bench plays both
//   the pipeline requesters and the RAM; a transaction-level reference model
//   tracks which request is being served and predicts the RAM command, hits
//   and returned data every cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic nRST;
    logic err;
`ifdef MEM_ARBITER_STATS_EN
    word_t icount, dcount;
`endif

    mem_arbiter_if bus();

    // RAM contents, word-indexed over a 1 KiB window
    word_t ram [0:255];
    assign bus.ramload = ram[bus.ramaddr[9:2]];

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (3)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus),
        .err    (err)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .icount (icount),
        .dcount (dcount)
`endif
    );

    int    checks = 0;
    int    errors = 0;

    // reference model: who is being served this cycle (0 none, 1 fetch, 2 data)
    int    cur;
    word_t cur_addr, cur_data;
    logic  cur_w;
    bit    just_done;     // an access ended last cycle; next edge only returns to idle
    int    streak;        // data grants taken while a fetch waited
    logic  err_exp;
    word_t exp_icnt, exp_dcnt;
    int    hit_log[$];
    bit    rnd;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    task automatic model_reset();
        cur       = 0;
        just_done = 1'b0;
        streak    = 0;
        err_exp   = 1'b0;
        exp_icnt  = '0;
        exp_dcnt  = '0;
    endtask

    task automatic clear_reqs();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    // arbitration rule applied at an edge where the arbiter is free
    task automatic model_edge();
        if (just_done) begin
            just_done = 1'b0;
        end else if (cur == 0) begin
            if ((bus.dREN || bus.dWEN) && !(bus.iREN && streak == STARVE_MAX)) begin
                cur      = 2;
                cur_addr = bus.daddr;
                cur_data = bus.dstore;
                cur_w    = bus.dWEN;
                if (bus.iREN) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
                else          streak = 0;
            end else if (bus.iREN) begin
                cur      = 1;
                cur_addr = bus.iaddr;
                streak   = 0;
            end
        end
    endtask

    task automatic rand_drive();
        if (!bus.iREN && $urandom_range(0, 3) == 0) begin
            bus.iREN  = 1'b1;
            bus.iaddr = rand_addr();
        end
        if (!bus.dREN && !bus.dWEN && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
                0:       begin bus.dREN = 1'b1; bus.dWEN = 1'b0; end
                1:       begin bus.dREN = 1'b0; bus.dWEN = 1'b1; end
                default: begin bus.dREN = 1'b1; bus.dWEN = 1'b1; end
            endcase
            bus.daddr  = rand_addr();
            bus.dstore = $urandom();
        end
        // wiggle the lines of the request already granted
        if (cur == 1 && $urandom_range(0, 1) == 1) bus.iaddr = rand_addr();
        if (cur == 2 && $urandom_range(0, 1) == 1) begin
            bus.daddr  = rand_addr();
            bus.dstore = $urandom();
        end
    endtask

    function automatic ramstate_t rand_rs();
        int r;
        r = int'($urandom_range(0, 63));
        if (r < 2)  return ERROR;
        if (r < 34) return ACCESS;
        if (r < 48) return BUSY;
        return FREE;
    endfunction

    // one clock cycle: edge, drive, check at the falling edge, retire
    task automatic step(input ramstate_t rs);
        bit hit_exp;
        model_edge();
        @(posedge CLK);
        #1;
        bus.ramstate = rs;
        if (rnd) rand_drive();
        @(negedge CLK);
        hit_exp = (cur != 0) && (rs == ACCESS);
        chk1("ramREN", bus.ramREN, (cur == 1) || (cur == 2 && !cur_w));
        chk1("ramWEN", bus.ramWEN, (cur == 2) && cur_w);
        chk1("ihit", bus.ihit, hit_exp && cur == 1);
        chk1("dhit", bus.dhit, hit_exp && cur == 2);
        chk1("err", err, err_exp);
        if (cur != 0) chk32("ramaddr", bus.ramaddr, cur_addr);
        if (cur == 2 && cur_w) chk32("ramstore", bus.ramstore, cur_data);
        if (hit_exp && cur == 1) chk32("iload", bus.iload, ram[cur_addr[9:2]]);
        if (hit_exp && cur == 2) chk32("dload", bus.dload, cur_w ? 32'h0 : ram[cur_addr[9:2]]);
`ifdef MEM_ARBITER_STATS_EN
        chk32("icount", icount, exp_icnt);
        chk32("dcount", dcount, exp_dcnt);
`endif
        // RAM commits whatever store the arbiter presents on ACCESS
        if (bus.ramWEN && rs == ACCESS) ram[bus.ramaddr[9:2]] = bus.ramstore;
        if (cur != 0 && (rs == ACCESS || rs == ERROR)) begin
            if (rs == ERROR) begin
                err_exp = 1'b1;
            end else begin
                hit_log.push_back(cur);
                if (cur == 1) begin
                    bus.iREN = 1'b0;
                    exp_icnt = exp_icnt + 32'd1;
                end else begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                    exp_dcnt = exp_dcnt + 32'd1;
                end
            end
            cur       = 0;
            just_done = 1'b1;
        end
    endtask

    initial begin
        rnd = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) ram[i] = $urandom();

        // ---- reset: requests and RAM ACCESS present, outputs must stay 0
        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = ACCESS;
        repeat (3) @(negedge CLK);
        chk1 ("rst_ramREN",   bus.ramREN,   1'b0);
        chk1 ("rst_ramWEN",   bus.ramWEN,   1'b0);
        chk1 ("rst_ihit",     bus.ihit,     1'b0);
        chk1 ("rst_dhit",     bus.dhit,     1'b0);
        chk1 ("rst_err",      err,          1'b0);
        chk32("rst_ramaddr",  bus.ramaddr,  32'h0);
        chk32("rst_ramstore", bus.ramstore, 32'h0);
        chk32("rst_iload",    bus.iload,    32'h0);
        chk32("rst_dload",    bus.dload,    32'h0);
        nRST = 1'b1;
        step(ACCESS);
        chk1 ("rel_ramREN",  bus.ramREN,  1'b1);
        chk32("rel_ramaddr", bus.ramaddr, 32'h40);
        step(FREE);

        // ---- simultaneous requests: data first, fetch two cycles later
        hit_log.delete();
        bus.iREN  = 1'b1; bus.iaddr = 32'h40;
        bus.dREN  = 1'b1; bus.daddr = 32'h100;
        for (int c = 1; c <= 4; c++) begin
            step(ACCESS);
            if (c == 1) chk1("sim_dhit_c1", bus.dhit, 1'b1);
            if (c == 3) chk1("sim_ihit_c3", bus.ihit, 1'b1);
        end
        chk32("sim_nhits", word_t'(hit_log.size()), 32'd2);
        if (hit_log.size() == 2) begin
            chk32("sim_first",  word_t'(hit_log[0]), 32'd2);
            chk32("sim_second", word_t'(hit_log[1]), 32'd1);
        end

        // ---- both data enables: store wins
        bus.dREN = 1'b1; bus.dWEN = 1'b1;
        bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        step(ACCESS);
        chk1("wp_ramWEN", bus.ramWEN, 1'b1);
        chk1("wp_ramREN", bus.ramREN, 1'b0);
        step(FREE);
        chk32("wp_ram", ram[128], 32'hDEADBEEF);

        // ---- starvation: fetch waits behind exactly STARVE_MAX data grants
        hit_log.delete();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dREN = 1'b1; bus.daddr = 32'h104;
        for (int c = 0; c < 60 && hit_log.size() < 10; c++) begin
            step(ACCESS);
            if (!bus.dREN) begin bus.dREN = 1'b1; bus.daddr = rand_addr(); end
            if (!bus.iREN) begin bus.iREN = 1'b1; bus.iaddr = rand_addr(); end
        end
        clear_reqs();
        chk32("starve_nhits", word_t'(hit_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < hit_log.size(); k++)
            chk32("starve_order", word_t'(hit_log[k]), (k % 5 == 4) ? 32'd1 : 32'd2);
        step(FREE);
        step(FREE);

        // ---- wait states: command held steady, single hit
        hit_log.delete();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        step(BUSY);
        bus.iaddr = 32'h84;
        step(BUSY);
        step(BUSY);
        step(ACCESS);
        chk32("ws_addr",  bus.ramaddr, 32'h80);
        chk32("ws_nhits", word_t'(hit_log.size()), 32'd1);
        step(FREE);

        // ---- RAM error: no hit, sticky err, requester retried
        bus.iREN = 1'b1; bus.iaddr = 32'h88;
        step(ERROR);
        chk1("er_nohit", bus.ihit, 1'b0);
        step(FREE);
        chk1("er_sticky", err, 1'b1);
        step(ACCESS);
        chk1 ("er_retry_hit",  bus.ihit,    1'b1);
        chk32("er_retry_addr", bus.ramaddr, 32'h88);
        step(FREE);

        // ---- asynchronous reset in the middle of a data access
        bus.dREN = 1'b1; bus.daddr = 32'h10;
        step(BUSY);
        chk1("ar_pre_ren", bus.ramREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk1("ar_ramREN", bus.ramREN, 1'b0);
        chk1("ar_dhit",   bus.dhit,   1'b0);
        chk1("ar_err",    err,        1'b0);
`ifdef MEM_ARBITER_STATS_EN
        chk32("ar_icount", icount, 32'h0);
        chk32("ar_dcount", dcount, 32'h0);
`endif
        clear_reqs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;

        // ---- randomized traffic against the model
        rnd = 1'b1;
        for (int c = 0; c < 3000; c++) step(rand_rs());
        rnd = 1'b0;
        clear_reqs();
        for (int c = 0; c < 20 && (cur != 0 || just_done); c++) step(ACCESS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences all datapath memory traffic onto the single-ported RAM.
- Sits between the pipeline's instruction-fetch and data-memory request lines and the RAM port.
- Grants one requester at a time through a small FSM and holds the granted request stable until RAM completes.
- Data accesses get priority; an anti-starvation counter guarantees instruction fetch progresses under back-to-back loads/stores.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before instruction fetch is forced.
- CNT_W, 3, width of starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction fetch request, held until ihit
- iaddr  input  32  instruction word address
- ihit  output  1  instruction access complete this cycle
- iload  output  32  fetched instruction, valid when ihit
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  32  data address
- dstore  input  32  store data
- dhit  output  1  data access complete this cycle
- dload  output  32  load data, valid when dhit
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- err  output  1  sticky flag, set on RAM ERROR, cleared only by reset

Behaviour:
- Reset (async, nRST low): state IDLE; starve_cnt 0; latched addr/data/write regs 0; err 0.
  All outputs 0 while in reset: ihit, dhit, ramREN, ramWEN, iload, dload, ramaddr, ramstore.
- FSM states: IDLE, IFETCH, DACCESS.
- IDLE: RAM enables 0. Transition on the next edge:
  - (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX) -> DACCESS.
  - else iREN -> IFETCH.
  - else stay IDLE.
- Grant edge latches request fields into internal regs: address, store data, write flag. The write flag is dWEN, so dWEN wins if dREN and dWEN are both high.
- IFETCH: ramREN=1, ramWEN=0, ramaddr=latched iaddr.
- DACCESS: ramREN=~wflag, ramWEN=wflag, ramaddr=latched daddr, ramstore=latched dstore.
- Completion:
  - In IFETCH or DACCESS with ramstate==ACCESS, the hit is combinational in that cycle: ihit=1 (iload=ramload) or dhit=1 (dload=ramload for reads, 0 for writes). Next state is IDLE.
  - BUSY or FREE: stay in the state, outputs held.
  - ERROR: no hit; set err; return to IDLE. The requester is re-arbitrated because it is still asserting.
- Minimum latency: request seen in IDLE at cycle N, RAM driven at N+1, hit at N+1 if RAM answers immediately. Steady-state throughput is one access per 2 cycles.
- Starvation counter: updated at each DACCESS grant.
  - Data grant with iREN high -> starve_cnt += 1, saturating at STARVE_MAX.
  - Any IFETCH grant, or a data grant with iREN low -> starve_cnt = 0.
- Requesters deasserting mid-access is a protocol violation. The latched access still completes and the hit still pulses.
- iaddr/daddr/dstore changing after grant has no effect until the next grant.
- Hits never assert in IDLE. ihit and dhit are never high in the same cycle.

Optional Feature:
- Macro MEM_ARBITER_STATS_EN.
- Defined: adds outputs icount[31:0] and dcount[31:0].
  - Increment on each ihit / dhit respectively; wrap at 2^32.
  - Reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg holds ramstate_t (existing), word_t, and a new arb_state_t enum {IDLE, IFETCH, DACCESS}.
- STARVE_MAX stays a module parameter.
- One natural sub-module: arb_starve_ctr (saturating counter with inc/clear/sat outputs).
- FSM, request latches and output mux stay in mem_arbiter.

Test Plan:
- Reset: hold nRST low with iREN=1, ramstate=ACCESS -> all outputs 0 and state IDLE. Release -> ramREN=1, ramaddr=iaddr one cycle later.
- Simultaneous: iREN=1 iaddr=0x40, dREN=1 daddr=0x100, RAM ACCESS every cycle -> dhit at cycle 1 with dload=RAM[0x100]; ihit at cycle 3 with iload=RAM[0x40].
- Write priority: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0. After dhit, RAM[0x200]=0xDEADBEEF.
- Starvation, STARVE_MAX=4: iREN held high, data requests continuously re-asserted -> exactly 4 dhits, then an ihit before the 5th dhit; counter then 0.
- Wait states and error: ramstate BUSY 3 cycles then ACCESS -> ramaddr/ramREN stable all 4 cycles, single ihit. ramstate ERROR -> err=1, no hit, retry granted.
- With MEM_ARBITER_STATS_EN: 3 fetches + 2 loads -> icount=3, dcount=2. Async reset mid-DACCESS -> counters 0, ramREN 0 immediately.
